conv_share_arbiter: RTL and testbench

- Shares one two's-complement-to-sign-magnitude message converter among N_REQ variable-node requesters.
- Round-robin burst arbitration feeds a 2-stage pipelined converter.
- Results return on a single response channel tagged with the requester id.
- Sits between the variable-node units and the check-node min-finder in the LDPC decoder.

---
 rtl/ldpc_msg_pkg.sv | 10 +
 rtl/msg_tc2sm_conv.sv | 15 +
 rtl/conv_share_arbiter.sv | 114 +++++++++++
 tb/tb_conv_share_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_msg_pkg.sv
// ldpc_msg_pkg: shared LDPC message widths, magnitude limit and sign-magnitude message type
package ldpc_msg_pkg;
    localparam int MSG_W = 7;
    localparam int SM_W = 8;
    localparam logic [MSG_W-1:0] SM_MAG_MAX = 7'd63;
    typedef struct packed {
        logic             sign;
        logic [MSG_W-1:0] mag;
    } sm_msg_t;
endpackage

// File: rtl/msg_tc2sm_conv.sv
// msg_tc2sm_conv: combinational two's-complement to sign-magnitude converter; ports tc (MSG_W in), sm (sm_msg_t out); CONV_SAT_EN clamps magnitude to SM_MAG_MAX
module msg_tc2sm_conv
    import ldpc_msg_pkg::*;
(
    input  logic [MSG_W-1:0] tc,
    output sm_msg_t          sm
);
    logic [MSG_W-1:0] mag;
    assign mag = tc[MSG_W-1] ? ~tc + MSG_W'(1) : tc;
`ifdef CONV_SAT_EN
    assign sm = {tc[MSG_W-1], (mag > SM_MAG_MAX) ? SM_MAG_MAX : mag};
`else
    assign sm = {tc[MSG_W-1], mag};
`endif
endmodule

// File: rtl/conv_share_arbiter.sv
// conv_share_arbiter: round-robin burst arbiter sharing one 2-stage tc->sm converter; ports clk, rst, req_valid/req_data/req_ready (per requester), rsp_valid/rsp_ready/rsp_data/rsp_id, busy; CONV_SAT_EN selects saturating conversion
module conv_share_arbiter
    import ldpc_msg_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [MSG_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [SM_W-1:0]        rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;
    logic [ID_W-1:0] rr_ptr, rr_ptr_nx, grant, grant_nx, pick, idx, s1_id, s2_id;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nx;
    logic found, hs, s1_valid, s2_valid, s1_can_accept, s2_can_accept;
    logic [MSG_W-1:0] s1_data;
    logic [MSG_W-1:0] req_msg [N_REQ];
    sm_msg_t conv, s2_data;

    for (genvar i = 0; i < N_REQ; i++) begin : g_msg
        assign req_msg[i] = req_data[i*MSG_W +: MSG_W];
    end

    msg_tc2sm_conv u_conv (.tc(s1_data), .sm(conv));

    assign s2_can_accept = !s2_valid | rsp_ready;
    assign s1_can_accept = !s1_valid | s2_can_accept;
    assign rsp_valid = s2_valid;
    assign rsp_data = s2_data;
    assign rsp_id = s2_id;
    assign busy = (state == BUSY) | s1_valid | s2_valid;

    always_comb begin
        pick = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k >= N_REQ) ? ID_W'(int'(rr_ptr) + k - N_REQ) : ID_W'(int'(rr_ptr) + k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        burst_cnt_nx = burst_cnt;
        rr_ptr_nx = rr_ptr;
        req_ready = '0;
        hs = 1'b0;
        if (state == IDLE) begin
            if (found) begin
                state_nx = BUSY;
                grant_nx = pick;
                burst_cnt_nx = '0;
            end
        end else begin
            req_ready[grant] = s1_can_accept;
            hs = req_valid[grant] & s1_can_accept;
            if (!req_valid[grant] || (hs && burst_cnt == CNT_W'(BURST_LEN - 1))) begin
                state_nx = IDLE;
                rr_ptr_nx = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end else if (hs) begin
                burst_cnt_nx = burst_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant <= '0;
            burst_cnt <= '0;
            s1_valid <= 1'b0;
            s1_data <= '0;
            s1_id <= '0;
            s2_valid <= 1'b0;
            s2_data <= '0;
            s2_id <= '0;
        end else begin
            state <= state_nx;
            rr_ptr <= rr_ptr_nx;
            grant <= grant_nx;
            burst_cnt <= burst_cnt_nx;
            if (hs) begin
                s1_valid <= 1'b1;
                s1_data <= req_msg[grant];
                s1_id <= grant;
            end else if (s2_can_accept) begin
                s1_valid <= 1'b0;
            end
            if (s2_can_accept) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= conv;
                    s2_id <= s1_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_share_arbiter.sv
// tb_conv_share_arbiter: directed self-checking bench for conv_share_arbiter (honours CONV_SAT_EN)
module tb_conv_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [27:0] req_data = '0;
    logic [3:0] req_ready;
    logic rsp_valid;
    logic rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [1:0] rsp_id;
    logic busy;
    int npass = 0;
    int nchk = 0;
    int cyc = 0;
    logic [6:0] q [4][$];
    int hlog[$], hcyc[$], rx[$], rcyc[$], ep[$], er[$];

    always #5 clk = ~clk;

    conv_share_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always @(negedge clk) begin
        int o;
        cyc++;
        o = 7;
        for (int i = 3; i >= 0; i--) if (req_valid[i] && req_ready[i]) o = i;
        hlog.push_back(o);
        hcyc.push_back(cyc);
        if (rsp_valid && rsp_ready) begin
            rx.push_back(int'({rsp_id, rsp_data}));
            rcyc.push_back(cyc);
        end
    end

    task automatic chk(string tag, int got, int exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_sm(logic [6:0] x);
        int v, m;
        v = x[6] ? int'(x) - 128 : int'(x);
        m = (v < 0) ? -v : v;
`ifdef CONV_SAT_EN
        if (m > 63) m = 63;
`endif
        return {x[6], 7'(m)};
    endfunction

    function automatic int first_hs();
        foreach (hlog[i]) if (hlog[i] != 7) return i;
        return -1;
    endfunction

    function automatic int pat_err();
        int s, e;
        s = first_hs();
        e = 0;
        if (s < 0) return ep.size();
        foreach (ep[i]) if (s + i >= hlog.size() || hlog[s+i] != ep[i]) e++;
        return e;
    endfunction

    function automatic int rx_err();
        int e;
        e = (rx.size() > er.size()) ? rx.size() - er.size() : er.size() - rx.size();
        foreach (er[i]) if (i >= rx.size() || rx[i] != er[i]) e++;
        return e;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = q[i].size() != 0;
            req_data[i*7 +: 7] = (q[i].size() != 0) ? q[i][0] : 7'd0;
        end
    endtask

    task automatic step();
        logic [3:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) void'(q[i].pop_front());
        drive();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        hlog.delete(); hcyc.delete(); rx.delete(); rcyc.delete(); ep.delete(); er.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        drive();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        clr();
    endtask

    initial begin
        int s, lat, n;
        logic [7:0] b0;
        steps(2);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        clr();

        // single requester, hand-computed conversions and 2-cycle latency
        q[1] = '{7'b1101100, 7'b1111000, 7'b0101010, 7'b0010101};
        drive();
        steps(12);
        chk("t1_beat0", rx.size() > 0 ? rx[0] : -1, 'h194);
        chk("t1_beat1", rx.size() > 1 ? rx[1] : -1, 'h188);
        chk("t1_beat2", rx.size() > 2 ? rx[2] : -1, 'h12A);
        chk("t1_beat3", rx.size() > 3 ? rx[3] : -1, 'h115);
        chk("t1_count", rx.size(), 4);
        s = first_hs();
        lat = (s < 0 || rcyc.size() == 0) ? -1 : rcyc[0] - hcyc[s];
        chk("t1_latency", lat, 2);

        // two streaming requesters, 8-beat bursts with one idle cycle between
        do_reset();
        for (int i = 0; i < 16; i++) q[0].push_back(7'(i * 9 + 100));
        for (int i = 0; i < 8; i++) q[2].push_back(7'(i * 13 + 3));
        for (int i = 0; i < 8; i++) begin ep.push_back(0); er.push_back(int'({2'd0, ref_sm(q[0][i])})); end
        ep.push_back(7);
        for (int i = 0; i < 8; i++) begin ep.push_back(2); er.push_back(int'({2'd2, ref_sm(q[2][i])})); end
        ep.push_back(7);
        for (int i = 8; i < 16; i++) begin ep.push_back(0); er.push_back(int'({2'd0, ref_sm(q[0][i])})); end
        drive();
        steps(40);
        chk("t2_grant_pattern", pat_err(), 0);
        chk("t2_rsp_stream", rx_err(), 0);

        // -64 and zero
        clr();
        q[0] = '{7'b1000000, 7'b0000000};
        drive();
        steps(10);
`ifdef CONV_SAT_EN
        chk("t3_min_neg", rx.size() > 0 ? rx[0] : -1, 'hBF);
`else
        chk("t3_min_neg", rx.size() > 0 ? rx[0] : -1, 'hC0);
`endif
        chk("t3_zero", rx.size() > 1 ? rx[1] : -1, 'h00);

        // backpressure: two accepts fill the pipe, then outputs hold
        clr();
        rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) q[1].push_back(7'(i * 23 + 70));
        b0 = ref_sm(q[1][0]);
        for (int i = 0; i < 10; i++) er.push_back(int'({2'd1, ref_sm(q[1][i])}));
        drive();
        steps(3);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold", int'({rsp_valid, rsp_id, rsp_data, req_ready}), int'({1'b1, 2'd1, b0, 4'b0}));
        end
        n = 0;
        foreach (hlog[i]) if (hlog[i] != 7) n++;
        chk("t4_accepts_in_hold", n, 2);
        rsp_ready = 1'b1;
        steps(25);
        chk("t4_rsp_stream", rx_err(), 0);

        // early release by valid drop, round-robin continues from requester 0
        clr();
        q[3] = '{7'd5, 7'd6, 7'd7};
        drive();
        step();
        q[0] = '{7'd1, 7'd2};
        q[2] = '{7'd3};
        drive();
        ep = '{3, 3, 3, 7, 7, 0, 0, 7, 7, 2};
        steps(16);
        chk("t5_grant_pattern", pat_err(), 0);

        // reset with both stages full and FSM busy
        rsp_ready = 1'b0;
        q[1] = '{7'd11, 7'd12, 7'd13, 7'd14, 7'd15};
        drive();
        steps(6);
        chk("t6_busy_before", int'({busy, rsp_valid}), 3);
        rst = 1'b1;
        step();
        chk("t6_rsp_valid", int'(rsp_valid), 0);
        chk("t6_req_ready", int'(req_ready), 0);
        chk("t6_busy", int'(busy), 0);
        rst = 1'b0;
        q[1].delete();
        rsp_ready = 1'b1;
        clr();
        q[0] = '{7'd33};
        q[3] = '{7'd44};
        drive();
        ep = '{0, 7, 7, 3};
        er = '{int'({2'd0, ref_sm(7'd33)}), int'({2'd3, ref_sm(7'd44)})};
        steps(12);
        chk("t6_restart_pattern", pat_err(), 0);
        chk("t6_rsp_after_reset", rx_err(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
